bsm_pixel_serializer: RTL and testbench

Background pixel serializer, downstream of the background scanline map (BSM) builder. Each BSM entry holds a 3-bit colour and one 16-bit, 8-pixel pattern line. The block walks the 32 entries of the current scanline in step with the GPU counters and emits one 2-bit background pixel per clock, tagged with its colour, x position and opacity. The pixel stream goes to the object/background compositor.

---
 rtl/bsm_pixel_serializer_pkg.sv | 34 +++
 rtl/bsm_pixel_serializer_if.sv | 37 +++
 rtl/bsm_pixel_serializer_tile_shifter.sv | 42 ++++
 rtl/bsm_pixel_serializer.sv | 155 +++++++++++++++
 tb/tb_bsm_pixel_serializer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bsm_pixel_serializer_pkg.sv
// Shared types and sizes for the background pixel serializer.
// BSM entry layout: [18:16] colour, [15:0] 8-pixel pattern line (MSB pair = leftmost).
package bsm_pixel_serializer_pkg;

    localparam int unsigned TILES           = 32;
    localparam int unsigned VISIBLE_W       = TILES * 8;
    localparam int unsigned COL_W           = $clog2(TILES);
    localparam int unsigned X_W             = $clog2(VISIBLE_W);
    localparam int unsigned BSM_ENTRY_WIDTH = 19;
    localparam int unsigned LINE_W          = 16;
    localparam int unsigned COLOR_W         = 3;
    localparam int unsigned PIX_W           = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_READY    = 2'd2,
        ST_DRAW     = 2'd3
    } state_e;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [LINE_W-1:0]  line;
    } bsm_entry_t;

    function automatic logic [COLOR_W-1:0] bsm_color(input bsm_entry_t e);
        return e.color;
    endfunction

    function automatic logic [LINE_W-1:0] bsm_line(input bsm_entry_t e);
        return e.line;
    endfunction

endpackage

// File: rtl/bsm_pixel_serializer_if.sv
// BSM read port plus the background pixel stream toward the compositor.
// master = serializer side, slave = BSM storage / compositor side.
interface bsm_pixel_serializer_if;
    import bsm_pixel_serializer_pkg::*;

    logic [COL_W-1:0]   bsm_col;
    bsm_entry_t         bsm_entry;
    logic               pix_valid;
    logic [X_W-1:0]     pix_x;
    logic [PIX_W-1:0]   pix_index;
    logic [COLOR_W-1:0] pix_color;
    logic               pix_opaque;
    logic               underrun;

    modport master (
        output bsm_col,
        input  bsm_entry,
        output pix_valid,
        output pix_x,
        output pix_index,
        output pix_color,
        output pix_opaque,
        output underrun
    );

    modport slave (
        input  bsm_col,
        output bsm_entry,
        input  pix_valid,
        input  pix_x,
        input  pix_index,
        input  pix_color,
        input  pix_opaque,
        input  underrun
    );

endinterface

// File: rtl/bsm_pixel_serializer_tile_shifter.sv
// 16-bit pattern shifter and colour register for the tile currently being drawn.
// Load has priority over shift; the current pixel is always the top pair.
module bsm_pixel_serializer_tile_shifter
    import bsm_pixel_serializer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               shift_i,
    input  bsm_entry_t         entry_i,
    output logic [PIX_W-1:0]   pix_o,
    output logic [COLOR_W-1:0] color_o
);

    logic [LINE_W-1:0]  line_q,  line_d;
    logic [COLOR_W-1:0] color_q, color_d;

    always_comb begin
        line_d  = line_q;
        color_d = color_q;
        if (load_i) begin
            line_d  = bsm_line(entry_i);
            color_d = bsm_color(entry_i);
        end else if (shift_i) begin
            line_d = {line_q[LINE_W-PIX_W-1:0], PIX_W'(0)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q  <= '0;
            color_q <= '0;
        end else begin
            line_q  <= line_d;
            color_q <= color_d;
        end
    end

    assign pix_o   = line_q[LINE_W-1 -: PIX_W];
    assign color_o = color_q;

endmodule

// File: rtl/bsm_pixel_serializer.sv
// Background pixel serializer: walks the 32 BSM entries of a scanline in step
// with the GPU x counter and emits one registered 2-bit pixel per clock.
module bsm_pixel_serializer
    import bsm_pixel_serializer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [X_W-1:0] xp_i,
    input  logic           hvisible_i,
    input  logic           vvisible_i,
    bsm_pixel_serializer_if.master bus
);

    state_e             state_q, state_d;
    logic               hv_q;
    logic               underrun_q, underrun_d;
    logic               pix_valid_q, pix_valid_d;
    logic [X_W-1:0]     pix_x_q, pix_x_d;
    logic [PIX_W-1:0]   pix_index_q, pix_index_d;
    logic [COLOR_W-1:0] pix_color_q, pix_color_d;
    logic               pix_opaque_q, pix_opaque_d;

    logic               hv_rise_c;
    logic               tile_last_c;
    logic               draw_c;
    logic               load_c;
    logic               shift_c;
    logic [COL_W-1:0]   col_next_c;
    logic [COL_W-1:0]   bsm_col_c;
    logic [PIX_W-1:0]   sh_pix;
    logic [COLOR_W-1:0] sh_color;

    assign hv_rise_c   = hvisible_i && !hv_q;
    assign tile_last_c = (xp_i[2:0] == 3'd7);
    assign col_next_c  = xp_i[X_W-1:3] + COL_W'(1);

    // Line sequencing: prefetch tile 0 during blank, then draw/reload tiles.
    always_comb begin
        state_d    = state_q;
        underrun_d = underrun_q;
        draw_c     = 1'b0;
        load_c     = 1'b0;
        shift_c    = 1'b0;
        bsm_col_c  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (hv_rise_c) begin
                    underrun_d = 1'b1;
                end else if (!hvisible_i) begin
                    state_d = ST_PREFETCH;
                end
            end
            ST_PREFETCH: begin
                bsm_col_c = '0;
                load_c    = 1'b1;
                if (hvisible_i) begin
                    underrun_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (hvisible_i) begin
                    state_d = ST_DRAW;
                    draw_c  = 1'b1;
                end
            end
            ST_DRAW: begin
                if (!hvisible_i) begin
                    state_d = ST_IDLE;
                end else begin
                    draw_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (draw_c) begin
            bsm_col_c = col_next_c;
            if (tile_last_c) begin
                load_c = 1'b1;
            end else begin
                shift_c = 1'b1;
            end
        end

        // Vertical blank overrides everything and never counts as an underrun.
        if (!vvisible_i) begin
            state_d    = ST_IDLE;
            underrun_d = underrun_q;
            draw_c     = 1'b0;
            load_c     = 1'b0;
            shift_c    = 1'b0;
            bsm_col_c  = '0;
        end
    end

    always_comb begin
        pix_valid_d  = draw_c;
        pix_x_d      = pix_x_q;
        pix_index_d  = pix_index_q;
        pix_color_d  = pix_color_q;
        pix_opaque_d = pix_opaque_q;
        if (draw_c) begin
            pix_x_d      = xp_i;
            pix_index_d  = sh_pix;
            pix_color_d  = sh_color;
            pix_opaque_d = |sh_pix;
        end
    end

    // hv_q resets high so a reset released mid-line is not seen as a line start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            hv_q         <= 1'b1;
            underrun_q   <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_index_q  <= '0;
            pix_color_q  <= '0;
            pix_opaque_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hv_q         <= hvisible_i;
            underrun_q   <= underrun_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_index_q  <= pix_index_d;
            pix_color_q  <= pix_color_d;
            pix_opaque_q <= pix_opaque_d;
        end
    end

    bsm_pixel_serializer_tile_shifter u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_c),
        .shift_i (shift_c),
        .entry_i (bus.bsm_entry),
        .pix_o   (sh_pix),
        .color_o (sh_color)
    );

    assign bus.bsm_col    = bsm_col_c;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_index  = pix_index_q;
    assign bus.pix_color  = pix_color_q;
    assign bus.pix_opaque = pix_opaque_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_bsm_pixel_serializer.sv
// Self-checking bench for bsm_pixel_serializer: table vectors, random BSM contents
// against a per-pixel reference, and hand-written reset/underrun/frame-end sequences.
module tb_bsm_pixel_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] xp;
    logic       hvisible;
    logic       vvisible;

    logic [18:0] bsm_mem [32];
    logic [4:0]  col_seen;
    logic        und_exp;

    int errors;
    int checks;

    logic       cap_valid [256];
    logic [1:0] cap_idx   [256];
    logic [2:0] cap_col   [256];
    logic       cap_op    [256];

    bsm_pixel_serializer_if bus ();

    assign bus.bsm_entry = bsm_mem[bus.bsm_col];

    bsm_pixel_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .xp_i       (xp),
        .hvisible_i (hvisible),
        .vvisible_i (vvisible),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] e0;
        logic [18:0] er;
        logic [7:0]  x;
        logic [1:0]  idx;
        logic [2:0]  col;
        logic        op;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference pixel: tile x/8, pixel x%8 counted from the pattern's MSB pair.
    function automatic logic [1:0] ref_idx(input int x);
        logic [18:0] e;
        logic [15:0] l;
        e = bsm_mem[5'(x / 8)];
        l = e[15:0] >> (14 - 2 * (x % 8));
        return l[1:0];
    endfunction

    function automatic logic [2:0] ref_col(input int x);
        logic [18:0] e;
        e = bsm_mem[5'(x / 8)];
        return e[18:16];
    endfunction

    task automatic cyc(input logic [7:0] x, input logic hv, input logic vv);
        xp       = x;
        hvisible = hv;
        vvisible = vv;
        #1;
        col_seen = bus.bsm_col;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pixel(input int x, input logic exp_draw);
        cap_valid[x] = bus.pix_valid;
        cap_idx[x]   = bus.pix_index;
        cap_col[x]   = bus.pix_color;
        cap_op[x]    = bus.pix_opaque;
        chk("pix_valid", 32'(bus.pix_valid), 32'(exp_draw));
        chk("underrun", 32'(bus.underrun), 32'(und_exp));
        if (exp_draw) begin
            chk("pix_x", 32'(bus.pix_x), 32'(x));
            chk("pix_index", 32'(bus.pix_index), 32'(ref_idx(x)));
            chk("pix_color", 32'(bus.pix_color), 32'(ref_col(x)));
            chk("pix_opaque", 32'(bus.pix_opaque), 32'(ref_idx(x) != 2'd0));
        end
    endtask

    task automatic run_line(input int blanks, input logic exp_draw);
        for (int b = 0; b < blanks; b++) begin
            cyc(8'd0, 1'b0, 1'b1);
            chk("blank_valid", 32'(bus.pix_valid), 32'd0);
        end
        for (int x = 0; x < 256; x++) begin
            cyc(8'(x), 1'b1, 1'b1);
            if (exp_draw && (x % 8 == 7))
                chk("bsm_col_reload", 32'(col_seen), 32'((x / 8 + 1) % 32));
            chk_pixel(x, exp_draw);
        end
    endtask

    task automatic fill(input logic [18:0] e0, input logic [18:0] er);
        bsm_mem[0] = e0;
        for (int k = 1; k < 32; k++) bsm_mem[k] = er;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 32; k++) bsm_mem[k] = 19'($urandom);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        und_exp  = 1'b0;
        rst      = 1'b0;
        xp       = 8'd0;
        hvisible = 1'b0;
        vvisible = 1'b0;
        fill(19'h0, 19'h0);

        vecs[0]  = '{19'h11B00, 19'h00000, 8'd0,   2'd0, 3'd1, 1'b0};
        vecs[1]  = '{19'h11B00, 19'h00000, 8'd1,   2'd1, 3'd1, 1'b1};
        vecs[2]  = '{19'h11B00, 19'h00000, 8'd2,   2'd2, 3'd1, 1'b1};
        vecs[3]  = '{19'h11B00, 19'h00000, 8'd3,   2'd3, 3'd1, 1'b1};
        vecs[4]  = '{19'h11B00, 19'h00000, 8'd4,   2'd0, 3'd1, 1'b0};
        vecs[5]  = '{19'h11B00, 19'h00000, 8'd7,   2'd0, 3'd1, 1'b0};
        vecs[6]  = '{19'h11B00, 19'h00000, 8'd8,   2'd0, 3'd0, 1'b0};
        vecs[7]  = '{19'h5FFFF, 19'h5FFFF, 8'd0,   2'd3, 3'd5, 1'b1};
        vecs[8]  = '{19'h5FFFF, 19'h5FFFF, 8'd127, 2'd3, 3'd5, 1'b1};
        vecs[9]  = '{19'h5FFFF, 19'h5FFFF, 8'd255, 2'd3, 3'd5, 1'b1};
        vecs[10] = '{19'h7C003, 19'h28000, 8'd0,   2'd3, 3'd7, 1'b1};
        vecs[11] = '{19'h7C003, 19'h28000, 8'd6,   2'd0, 3'd7, 1'b0};
        vecs[12] = '{19'h7C003, 19'h28000, 8'd7,   2'd3, 3'd7, 1'b1};
        vecs[13] = '{19'h7C003, 19'h28000, 8'd8,   2'd2, 3'd2, 1'b1};
        vecs[14] = '{19'h7C003, 19'h28000, 8'd9,   2'd0, 3'd2, 1'b0};

        // Reset values.
        #2;
        chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_pix_x", 32'(bus.pix_x), 32'd0);
        chk("rst_pix_index", 32'(bus.pix_index), 32'd0);
        chk("rst_pix_color", 32'(bus.pix_color), 32'd0);
        chk("rst_pix_opaque", 32'(bus.pix_opaque), 32'd0);
        chk("rst_underrun", 32'(bus.underrun), 32'd0);
        chk("rst_bsm_col", 32'(bus.bsm_col), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(8'd0, 1'b0, 1'b0);
        cyc(8'd0, 1'b0, 1'b0);

        // Table vectors: render one line per BSM configuration, then spot-check.
        for (int i = 0; i < 15; i++) begin
            if (i == 0 || vecs[i].e0 !== bsm_mem[0] || vecs[i].er !== bsm_mem[1]) begin
                fill(vecs[i].e0, vecs[i].er);
                run_line(4, 1'b1);
            end
            chk("vec_valid", 32'(cap_valid[vecs[i].x]), 32'd1);
            chk("vec_index", 32'(cap_idx[vecs[i].x]), 32'(vecs[i].idx));
            chk("vec_color", 32'(cap_col[vecs[i].x]), 32'(vecs[i].col));
            chk("vec_opaque", 32'(cap_op[vecs[i].x]), 32'(vecs[i].op));
        end

        // Tile boundaries: colour k%8 on every tile, colour steps exactly at 8k.
        for (int k = 0; k < 32; k++) bsm_mem[k] = {3'(k % 8), 16'h5555};
        run_line(4, 1'b1);
        for (int k = 1; k < 32; k++) begin
            chk("tile_edge_prev", 32'(cap_col[8 * k - 1]), 32'((k - 1) % 8));
            chk("tile_edge_new", 32'(cap_col[8 * k]), 32'(k % 8));
        end

        // Random BSM contents against the reference.
        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_line(4, 1'b1);
        end

        // Frame end: hvisible and vvisible drop together after xp=255.
        cyc(8'd0, 1'b0, 1'b0);
        chk("frame_end_valid", 32'(bus.pix_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(8'd0, 1'b0, 1'b0);
            chk("vblank_valid", 32'(bus.pix_valid), 32'd0);
        end

        // Underrun: only one blank cycle after vvisible returns.
        fill_random();
        cyc(8'd0, 1'b0, 1'b1);
        chk("pre_underrun", 32'(bus.underrun), 32'd0);
        und_exp = 1'b1;
        run_line(0, 1'b0);
        run_line(4, 1'b1);

        // Reset mid-DRAW at xp=100, released at xp=120 while still visible.
        fill_random();
        for (int b = 0; b < 4; b++) cyc(8'd0, 1'b0, 1'b1);
        for (int x = 0; x < 100; x++) begin
            cyc(8'(x), 1'b1, 1'b1);
            chk_pixel(x, 1'b1);
        end
        xp = 8'd100;
        rst = 1'b0;
        #1;
        und_exp = 1'b0;
        chk("mid_rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("mid_rst_pix_x", 32'(bus.pix_x), 32'd0);
        chk("mid_rst_pix_index", 32'(bus.pix_index), 32'd0);
        chk("mid_rst_pix_color", 32'(bus.pix_color), 32'd0);
        chk("mid_rst_pix_opaque", 32'(bus.pix_opaque), 32'd0);
        chk("mid_rst_underrun", 32'(bus.underrun), 32'd0);
        chk("mid_rst_bsm_col", 32'(bus.bsm_col), 32'd0);
        @(posedge clk);
        #1;
        for (int x = 101; x < 256; x++) begin
            if (x == 120) rst = 1'b1;
            cyc(8'(x), 1'b1, 1'b1);
            chk("post_rst_valid", 32'(bus.pix_valid), 32'd0);
            chk("post_rst_underrun", 32'(bus.underrun), 32'd0);
        end
        run_line(4, 1'b1);

        cyc(8'd0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
